// File: rtl/prog_loader_pkg.sv
//------------------------------------------------------------------------------
// Module : prog_loader_pkg
// Brief  : Shared types and constants for the boot-time program loader.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package prog_loader_pkg;

    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DATA_W     = 8;
    localparam int LEN_ZERO_MEANS = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/prog_loader_if.sv
//------------------------------------------------------------------------------
// Module : prog_loader_if
// Brief  : Host stream, memory write port and core status bundle of the loader.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              reload;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              core_hold;
    logic              done;
    logic              err;

    // Host / memory / core side
    modport master (
        output in_valid, in_data, reload,
        input  in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, err
    );

    // Loader side
    modport slave (
        input  in_valid, in_data, reload,
        output in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, err
    );

endinterface

`default_nettype wire

// File: rtl/prog_loader_ld_cksum.sv
//------------------------------------------------------------------------------
// Module : ld_cksum
// Brief  : Modulo-2^DATA_W running sum with a zero check of sum + incoming byte.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ld_cksum
    import prog_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              clear_i,
    input  wire logic              add_i,
    input  wire logic [DATA_W-1:0] byte_i,
    output logic                   zero_o
);

    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] total;

    assign total  = sum_q + byte_i;
    assign zero_o = (total == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (clear_i) begin
            sum_q <= '0;
        end else if (add_i) begin
            sum_q <= total;
        end
    end

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
//------------------------------------------------------------------------------
// Module : prog_loader
// Brief  : Holds the core, writes a length-prefixed byte stream into instruction
//          memory from address 0, then releases the core.
//          Optional trailing checksum: define PROG_LOADER_CHECKSUM_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    prog_loader_if.slave  bus
);

    // Remaining-byte count needs one extra bit so that length 0 can mean 2^DATA_W
    localparam int                CNT_W  = DATA_W + 1;
    localparam logic [CNT_W-1:0]  N_ZERO = CNT_W'(LEN_ZERO_MEANS);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q;
    logic [CNT_W-1:0]    rem_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                accept;
    logic                last_byte;

    assign accept    = bus.in_valid & bus.in_ready;
    assign last_byte = (rem_q == CNT_W'(1));

`ifdef PROG_LOADER_CHECKSUM_EN
    logic sum_ok;

    ld_cksum #(.DATA_W(DATA_W)) u_cksum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (accept && (state_q == ST_IDLE)),
        .add_i   (accept && (state_q == ST_LOAD)),
        .byte_i  (bus.in_data),
        .zero_o  (sum_ok)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_LOAD;
            ST_LOAD: begin
                if (accept && last_byte) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHECK: if (accept) state_d = sum_ok ? ST_DONE : ST_ERR;
            ST_ERR:   if (bus.reload) state_d = ST_IDLE;
`endif
            ST_DONE: if (bus.reload) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_CHECK);
        bus.core_hold = (state_q != ST_DONE);
        bus.done      = (state_q == ST_DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
        bus.err       = (state_q == ST_ERR);
`else
        bus.err       = 1'b0;
`endif
    end

    // Write port is registered; address/data hold their last values between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (accept) begin
                case (state_q)
                    ST_IDLE: begin
                        cnt_q <= '0;
                        rem_q <= (bus.in_data == '0) ? N_ZERO : {1'b0, bus.in_data};
                    end
                    ST_LOAD: begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= cnt_q;
                        mem_wdata_q <= bus.in_data;
                        cnt_q       <= cnt_q + ADDR_W'(1);
                        rem_q       <= rem_q - CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
//------------------------------------------------------------------------------
// Module : tb_prog_loader
// Brief  : Randomized self-checking bench for prog_loader against a stream model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_prog_loader;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    prog_loader    #(.ADDR_W(8), .DATA_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0] wa[$];
    logic [7:0] wd[$];
    int         wc[$];
    logic       wdone[$];
    logic       whold[$];
    logic [7:0] pay_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
            wc.push_back(cyc);
            wdone.push_back(bus.done);
            whold.push_back(bus.core_hold);
        end
    end

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete(); wdone.delete(); whold.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct, input int rl_pct);
        bit sent   = 1'b0;
        int budget = 200;
        while (!sent && budget > 0) begin
            @(negedge clk);
            budget--;
            bus.reload = ($urandom_range(99) < rl_pct);
            if ($urandom_range(99) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = b;
                sent = (bus.in_ready === 1'b1);
            end
        end
        if (!sent) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: in_ready never high for byte %h", b);
        end
    endtask

    // Model: payload byte i lands at address i mod 256; outcome depends only on checksum
    task automatic run_stream(input string name, input int gap, input int rl, input bit bad);
        int         n = pay_q.size();
        int         k = 0;
        logic [7:0] len = (n == 256) ? 8'd0 : 8'(n);
        logic       exp_done = !bad;
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] sum = 8'd0;
        logic [7:0] ck;
`endif
        clear_log();
        send_byte(len, gap, rl);
        foreach (pay_q[i]) begin
            send_byte(pay_q[i], gap, rl);
`ifdef PROG_LOADER_CHECKSUM_EN
            sum = sum + pay_q[i];
`endif
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        ck = 8'd0 - sum;
        if (bad) ck = ck + 8'd1;
        send_byte(ck, gap, rl);
`endif
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.reload   = 1'b0;
        while (!(bus.done === 1'b1 || bus.err === 1'b1) && k < 20) begin
            @(negedge clk);
            k++;
        end
        #1;
        n_cmp++;
        if (k >= 20) begin n_fail++; $display("FAIL %s end_timeout: done=%b err=%b, need one high", name, bus.done, bus.err); end
        n_cmp++;
        if (wa.size() !== n) begin n_fail++; $display("FAIL %s write_count: got %0d need %0d", name, wa.size(), n); end
        for (int i = 0; i < n && i < wa.size(); i++) begin
            n_cmp++;
            if (wa[i] !== 8'(i) || wd[i] !== pay_q[i]) begin
                n_fail++;
                $display("FAIL %s write[%0d]: got addr %h data %h need addr %h data %h", name, i, wa[i], wd[i], 8'(i), pay_q[i]);
            end
        end
        n_cmp++;
        if (bus.done !== exp_done || bus.err !== !exp_done) begin
            n_fail++; $display("FAIL %s outcome: got done=%b err=%b need done=%b err=%b", name, bus.done, bus.err, exp_done, !exp_done);
        end
        n_cmp++;
        if (bus.core_hold !== !exp_done || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s hold_ready: got hold=%b ready=%b need hold=%b ready=0", name, bus.core_hold, bus.in_ready, !exp_done);
        end
    endtask

    task automatic do_reload(input string name);
        @(negedge clk);
        bus.reload = 1'b1;
        @(negedge clk);
        bus.reload = 1'b0;
        n_cmp++;
        if ({bus.in_ready, bus.core_hold, bus.done, bus.err} !== 4'b1100) begin
            n_fail++;
            $display("FAIL %s reload: got ready/hold/done/err=%b%b%b%b need 1100", name, bus.in_ready, bus.core_hold, bus.done, bus.err);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        bus.reload   = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.in_ready  !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b need 1", bus.in_ready); end
        n_cmp++; if (bus.core_hold !== 1'b1) begin n_fail++; $display("FAIL reset_core_hold: got %b need 1", bus.core_hold); end
        n_cmp++; if (bus.mem_we    !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b need 0", bus.mem_we); end
        n_cmp++; if (bus.done      !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b need 0", bus.done); end
        n_cmp++; if (bus.err       !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b need 0", bus.err); end
        n_cmp++; if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_addr_data: got %h/%h need 00/00", bus.mem_addr, bus.mem_wdata); end
        n_cmp++; if (wa.size() !== 0) begin n_fail++; $display("FAIL reset_no_write: got %0d writes need 0", wa.size()); end
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        pay_q = '{8'hA0, 8'hB1, 8'hC2};
        run_stream("b2b", 0, 0, 1'b0);
        for (int i = 1; i < 3 && i < wc.size(); i++) begin
            n_cmp++;
            if (wc[i] !== wc[0] + i) begin n_fail++; $display("FAIL b2b_consecutive[%0d]: got cycle %0d need %0d", i, wc[i], wc[0] + i); end
        end
`ifndef PROG_LOADER_CHECKSUM_EN
        if (wdone.size() == 3) begin
            n_cmp++;
            if (wdone[2] !== 1'b1 || whold[2] !== 1'b0 || wdone[1] !== 1'b0) begin
                n_fail++; $display("FAIL b2b_done_on_last_pulse: got done1=%b done2=%b hold2=%b need 0 1 0", wdone[1], wdone[2], whold[2]);
            end
        end
`endif
        do_reload("b2b");
    endtask

    task automatic test_len_zero();
        pay_q.delete();
        for (int i = 0; i < 256; i++) pay_q.push_back(8'(i));
        run_stream("len256", 30, 10, 1'b0);
        n_cmp++;
        if (dut.cnt_q !== 8'h00) begin n_fail++; $display("FAIL len256_counter_wrap: got %h need 00", dut.cnt_q); end
        do_reload("len256");
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pay_q = '{8'h01, 8'h02};
        run_stream("ck_good", 0, 0, 1'b0);
        do_reload("ck_good");
        run_stream("ck_bad", 0, 0, 1'b1);
        do_reload("ck_bad");
    endtask
`endif

    task automatic test_reset_mid();
        send_byte(8'd4, 0, 0);
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.core_hold, bus.mem_we, bus.done, bus.err} !== 5'b11000 || bus.mem_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ready/hold/we/done/err=%b%b%b%b%b addr=%h need 11000 addr=00",
                     bus.in_ready, bus.core_hold, bus.mem_we, bus.done, bus.err, bus.mem_addr);
        end
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        pay_q.delete();
        for (int i = 0; i < 4; i++) pay_q.push_back(8'($urandom));
        run_stream("midreset_resend", 20, 0, 1'b0);
    endtask

    task automatic test_done_hold();
        int nw = wa.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            n_cmp++;
            if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL done_hold_ready[%0d]: got %b need 0", i, bus.in_ready); end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++;
        if (wa.size() !== nw) begin n_fail++; $display("FAIL done_hold_no_write: got %0d writes need %0d", wa.size(), nw); end
        do_reload("done_hold");
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            int n = $urandom_range(1, 40);
            bit bad = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            bad = 1'($urandom_range(1));
`endif
            pay_q.delete();
            for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
            run_stream($sformatf("rand%0d", t), 25, 10, bad);
            do_reload($sformatf("rand%0d", t));
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.reload   = 1'b0;
        test_reset();
        test_back_to_back();
        test_len_zero();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        test_done_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader for the 8-bit accumulator core. It is the writer side of the core's instruction memory: while it holds the core stalled, it accepts a length-prefixed byte stream from a host over a valid/ready handshake and writes each byte into memory starting at address 0. On completion it releases the core, which then fetches from address 0.

## Interface
Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory/stream byte width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  host byte valid.
- in_ready  out  1  loader can accept a byte this cycle.
- in_data  in  DATA_W  host byte.
- reload  in  1  one-cycle pulse; starts a new session from DONE or ERR.
- mem_we  out  1  memory write enable, one cycle per payload byte.
- mem_addr  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W  memory write data.
- core_hold  out  1  stalls the core (gates PC/instruction fetch) while high.
- done  out  1  load completed successfully; level.
- err  out  1  load failed (checksum mismatch); level.

## Operation
- Transfer: a byte is accepted on a rising edge where in_valid && in_ready. in_data must be stable while in_valid is high; in_valid may drop at any time (gaps allowed).
- Stream format: length byte L, then N payload bytes, with N = L, except L = 0 meaning N = 256.
- FSM states: IDLE, LOAD, CHECK (only with checksum), DONE, ERR.
  - IDLE: in_ready=1. On accept, latch N, clear address counter and sum, go to LOAD.
  - LOAD: in_ready=1. Each accepted byte is written to mem_addr = counter; counter increments modulo 2^ADDR_W. The N-th byte goes to CHECK if checksum is compiled in, otherwise to DONE.
  - CHECK: in_ready=1. On accept, go to DONE if (sum + byte) mod 256 == 0, else go to ERR.
  - DONE: in_ready=0, done=1, core_hold=0. reload goes to IDLE.
  - ERR: in_ready=0, err=1, core_hold=1. reload goes to IDLE.
- reload is ignored in IDLE, LOAD and CHECK.
- core_hold is 1 in every state except DONE.
- The length byte and the checksum byte are never written to memory.
- Reset mid-session: all state returns to reset values immediately. Memory bytes already written are left as they are. The host must resend the whole stream.

## Timing
- Reset values: state IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, done=0, err=0, counter=0.
- Write latency: mem_we, mem_addr and mem_wdata are registered. They are asserted in the cycle after the byte is accepted, for exactly one cycle. mem_addr and mem_wdata hold their last values when mem_we=0.
- Back-to-back accepts produce back-to-back write pulses, one byte per cycle.
- done (or err) rises in the cycle after the final accepted byte. That is the same cycle as the last mem_we pulse when no checksum is used. core_hold falls in that same cycle.
- reload accepted in DONE or ERR: the next cycle shows IDLE, in_ready=1, core_hold=1, done=0, err=0.
- The 256-byte case: the counter runs 0..255 and wraps to 0 after the last byte; there is no extra write.

## Configuration
- PROG_LOADER_CHECKSUM_EN defined:
  - An 8-bit modulo-256 running sum is kept over the payload.
  - After the payload, one trailing checksum byte is required; the payload sum plus this byte must equal 0 mod 256.
  - A mismatch goes to ERR, and the core stays held.
- PROG_LOADER_CHECKSUM_EN undefined:
  - The CHECK and ERR states and the sum register are not built.
  - err is tied to 0.
  - LOAD goes directly to DONE.

## Structure
- Shared package prog_loader_pkg holds:
  - the state enum (IDLE, LOAD, CHECK, DONE, ERR);
  - the default ADDR_W and DATA_W;
  - the constant LEN_ZERO_MEANS = 256.
- One sub-module is natural: ld_cksum, the running-sum accumulator.
  - Inputs: clear, add-enable, byte.
  - Output: a zero-check flag for sum + byte.
  - Instantiated only under PROG_LOADER_CHECKSUM_EN.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 -> in_ready=1, core_hold=1, mem_we=0, done=0, err=0, and no write occurs.
- No checksum, L=03, payload A0 B1 C2 sent back-to-back -> mem_we pulses at addr 0/1/2 with A0/B1/C2 on three consecutive cycles, done=1 and core_hold=0 on the third pulse cycle.
- L=00, then 256 incrementing bytes with random in_valid gaps -> 256 writes at addr 0..255 with data equal to addr, done after byte 255, counter wrapped to 0.
- Checksum enabled, L=02, payload 01 02:
  - checksum byte FD -> done=1.
  - checksum byte FE -> err=1, core_hold=1, in_ready=0; then a reload pulse -> IDLE with err=0.
- rst_n pulsed low after 2 of 4 payload bytes -> outputs return to reset values; a full resend of L=04 writes addr 0..3 and ends with done=1.
- In DONE, hold in_valid=1 for 5 cycles -> in_ready=0 and no mem_we; reload -> core_hold=1 the next cycle.
